// File: rtl/nios_system_sdram_nios2_qsys_0_ocimem_arbiter.sv
// nios_system_sdram_nios2_qsys_0_ocimem_arbiter: shares the OCI RAM port between JTAG monitor commands and the CPU debug slave
module nios_system_sdram_nios2_qsys_0_ocimem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic [37:0]       jdo,
  input  logic [ADDR_W-1:0] av_address,
  input  logic              av_read,
  input  logic              av_write,
  input  logic [DATA_W-1:0] av_writedata,
  output logic [DATA_W-1:0] av_readdata,
  output logic              av_waitrequest,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wren,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] MonDReg,
  output logic [ADDR_W-1:0] MonAReg,
  output logic              monitor_ready,
  output logic              cmd_overrun
);
  typedef enum logic [1:0] {IDLE, J_RD, C_RD} state_t;
  state_t state, state_nx;
  logic pend, pend_rd, last_j, creq, grant_j, grant_c, j_done, cmd_any;
  logic [DATA_W-1:0] pend_data;
  logic unused;
  assign unused = ^jdo;
  assign av_readdata = ram_rdata;
  assign cmd_any = take_action_ocimem_a | take_action_ocimem_b;
  // arbitration, RAM port steering, CPU stall and next state
  always_comb begin
    creq = av_read | av_write;
    grant_j = reset_n && state == IDLE && pend && (!creq || !last_j);
    grant_c = reset_n && state == IDLE && creq && !grant_j;
    j_done = (grant_j && !pend_rd) || state == J_RD;
    ram_wren = (grant_j && !pend_rd) || (grant_c && av_write);
    ram_addr = (grant_j || state == J_RD) ? MonAReg : av_address;
    ram_wdata = grant_j ? pend_data : av_writedata;
    av_waitrequest = creq && !((grant_c && av_write) || state == C_RD);
    state_nx = (grant_j && pend_rd) ? J_RD : (grant_c && !av_write) ? C_RD : IDLE;
  end
  // FSM, JTAG command queue and monitor registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      pend <= 1'b0;
      pend_rd <= 1'b0;
      pend_data <= '0;
      last_j <= 1'b0;
      MonAReg <= '0;
      MonDReg <= '0;
      monitor_ready <= 1'b0;
      cmd_overrun <= 1'b0;
    end else begin
      state <= state_nx;
      if (grant_j) last_j <= 1'b1;
      else if (grant_c) last_j <= 1'b0;
      if (j_done) begin
        pend <= 1'b0;
        MonAReg <= MonAReg + 1'b1;
        monitor_ready <= 1'b1;
      end
      if (state == J_RD) MonDReg <= ram_rdata;
      if (cmd_any && (pend || (take_action_ocimem_a && take_action_ocimem_b))) cmd_overrun <= 1'b1;
      if (cmd_any) monitor_ready <= 1'b0;
      if (!pend && take_action_ocimem_b) begin
        pend <= 1'b1;
        pend_rd <= 1'b0;
        pend_data <= jdo[DATA_W+2:3];
      end else if (!pend && take_action_ocimem_a) begin
        MonAReg <= jdo[ADDR_W+1:2];
        pend <= jdo[36];
        pend_rd <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_nios_system_sdram_nios2_qsys_0_ocimem_arbiter.sv
// tb_nios_system_sdram_nios2_qsys_0_ocimem_arbiter: directed checks of JTAG/CPU sharing of the OCI RAM
module tb_nios_system_sdram_nios2_qsys_0_ocimem_arbiter;
  logic clk = 0, reset_n = 0, ta = 0, tb = 0, av_read = 0, av_write = 0;
  logic [37:0] jdo = '0;
  logic [7:0] av_address = '0, ram_addr, MonAReg;
  logic [31:0] av_writedata = '0, av_readdata, ram_wdata, ram_rdata, MonDReg;
  logic av_waitrequest, ram_wren, monitor_ready, cmd_overrun;
  logic [31:0] mem [256];
  int errors = 0, checks = 0;

  nios_system_sdram_nios2_qsys_0_ocimem_arbiter dut (
    .clk(clk), .reset_n(reset_n), .take_action_ocimem_a(ta), .take_action_ocimem_b(tb),
    .jdo(jdo), .av_address(av_address), .av_read(av_read), .av_write(av_write),
    .av_writedata(av_writedata), .av_readdata(av_readdata), .av_waitrequest(av_waitrequest),
    .ram_addr(ram_addr), .ram_wren(ram_wren), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .MonDReg(MonDReg), .MonAReg(MonAReg), .monitor_ready(monitor_ready), .cmd_overrun(cmd_overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_wren) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_a(input logic [7:0] addr, input logic rd);
    jdo = {1'b0, rd, 26'b0, addr, 2'b00};
    ta = 1;
    tick();
    ta = 0;
  endtask

  task automatic pulse_b(input logic [31:0] data);
    jdo = {3'b000, data, 3'b000};
    tb = 1;
    tick();
    tb = 0;
  endtask

  task automatic do_reset();
    reset_n = 0;
    tick();
    tick();
    reset_n = 1;
    tick();
  endtask

  task automatic test_reset();
    reset_n = 0;
    av_write = 1;
    av_address = 8'h33;
    tick();
    checks++; if (av_waitrequest !== 1'b1) begin errors++; $display("FAIL reset_waitreq: got %b want 1", av_waitrequest); end
    checks++; if (ram_wren !== 1'b0) begin errors++; $display("FAIL reset_wren: got %b want 0", ram_wren); end
    av_write = 0;
    tick();
    reset_n = 1;
    tick();
    checks++; if (MonDReg !== 32'h0) begin errors++; $display("FAIL reset_mondreg: got %h want 0", MonDReg); end
    checks++; if (MonAReg !== 8'h0) begin errors++; $display("FAIL reset_monareg: got %h want 0", MonAReg); end
    checks++; if (monitor_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", monitor_ready); end
    checks++; if (cmd_overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b want 0", cmd_overrun); end
    checks++; if (ram_wren !== 1'b0 || av_waitrequest !== 1'b0) begin errors++; $display("FAIL idle_outputs: got wren=%b wait=%b want 0 0", ram_wren, av_waitrequest); end
  endtask

  task automatic test_jtag_rw();
    pulse_a(8'h10, 1'b0);
    checks++; if (MonAReg !== 8'h10) begin errors++; $display("FAIL a_load: got %h want 10", MonAReg); end
    pulse_b(32'hDEADBEEF);
    checks++; if (ram_wren !== 1'b1 || ram_addr !== 8'h10 || ram_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL b_write: got wren=%b addr=%h data=%h want 1 10 deadbeef", ram_wren, ram_addr, ram_wdata); end
    tick();
    checks++; if (monitor_ready !== 1'b1) begin errors++; $display("FAIL b_ready: got %b want 1", monitor_ready); end
    checks++; if (mem[8'h10] !== 32'hDEADBEEF) begin errors++; $display("FAIL b_ram: got %h want deadbeef", mem[8'h10]); end
    checks++; if (MonAReg !== 8'h11) begin errors++; $display("FAIL b_inc: got %h want 11", MonAReg); end
    pulse_a(8'h10, 1'b1);
    checks++; if (monitor_ready !== 1'b0 || ram_addr !== 8'h10 || ram_wren !== 1'b0) begin errors++; $display("FAIL rd_issue: got ready=%b addr=%h wren=%b want 0 10 0", monitor_ready, ram_addr, ram_wren); end
    tick();
    checks++; if (ram_wren !== 1'b0 || monitor_ready !== 1'b0) begin errors++; $display("FAIL rd_jrd: got wren=%b ready=%b want 0 0", ram_wren, monitor_ready); end
    tick();
    checks++; if (MonDReg !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data: got %h want deadbeef", MonDReg); end
    checks++; if (MonAReg !== 8'h11 || monitor_ready !== 1'b1) begin errors++; $display("FAIL rd_done: got addr=%h ready=%b want 11 1", MonAReg, monitor_ready); end
  endtask

  task automatic test_wrap();
    pulse_a(8'hFF, 1'b0);
    pulse_b(32'h1);
    tick();
    pulse_b(32'h2);
    tick();
    checks++; if (mem[8'hFF] !== 32'h1) begin errors++; $display("FAIL wrap_ff: got %h want 1", mem[8'hFF]); end
    checks++; if (mem[8'h00] !== 32'h2) begin errors++; $display("FAIL wrap_00: got %h want 2", mem[8'h00]); end
    checks++; if (MonAReg !== 8'h01) begin errors++; $display("FAIL wrap_addr: got %h want 01", MonAReg); end
  endtask

  task automatic test_cpu();
    av_write = 1;
    av_address = 8'h20;
    av_writedata = 32'h55;
    #1;
    checks++; if (av_waitrequest !== 1'b0 || ram_wren !== 1'b1 || ram_addr !== 8'h20) begin errors++; $display("FAIL cpu_wr: got wait=%b wren=%b addr=%h want 0 1 20", av_waitrequest, ram_wren, ram_addr); end
    tick();
    av_write = 0;
    av_read = 1;
    #1;
    checks++; if (av_waitrequest !== 1'b1 || ram_wren !== 1'b0) begin errors++; $display("FAIL cpu_rd_wait: got wait=%b wren=%b want 1 0", av_waitrequest, ram_wren); end
    tick();
    checks++; if (av_waitrequest !== 1'b0 || av_readdata !== 32'h55) begin errors++; $display("FAIL cpu_rd_data: got wait=%b data=%h want 0 55", av_waitrequest, av_readdata); end
    av_read = 0;
    tick();
  endtask

  task automatic test_contention();
    do_reset();
    pulse_b(32'hA5A5);
    av_read = 1;
    av_address = 8'h20;
    #1;
    checks++; if (ram_wren !== 1'b1 || ram_addr !== 8'h00 || av_waitrequest !== 1'b1) begin errors++; $display("FAIL c1_jtag_first: got wren=%b addr=%h wait=%b want 1 00 1", ram_wren, ram_addr, av_waitrequest); end
    tick();
    checks++; if (ram_wren !== 1'b0 || ram_addr !== 8'h20 || av_waitrequest !== 1'b1) begin errors++; $display("FAIL c1_cpu_grant: got wren=%b addr=%h wait=%b want 0 20 1", ram_wren, ram_addr, av_waitrequest); end
    tick();
    checks++; if (av_waitrequest !== 1'b0 || av_readdata !== 32'h55) begin errors++; $display("FAIL c1_cpu_done: got wait=%b data=%h want 0 55", av_waitrequest, av_readdata); end
    av_read = 0;
    tick();
    checks++; if (mem[8'h00] !== 32'hA5A5) begin errors++; $display("FAIL c1_ram: got %h want a5a5", mem[8'h00]); end
    pulse_b(32'h1111);
    tick();
    pulse_b(32'h2222);
    av_read = 1;
    #1;
    checks++; if (ram_wren !== 1'b0 || ram_addr !== 8'h20 || av_waitrequest !== 1'b1) begin errors++; $display("FAIL c2_cpu_first: got wren=%b addr=%h wait=%b want 0 20 1", ram_wren, ram_addr, av_waitrequest); end
    tick();
    checks++; if (av_waitrequest !== 1'b0 || av_readdata !== 32'h55) begin errors++; $display("FAIL c2_cpu_done: got wait=%b data=%h want 0 55", av_waitrequest, av_readdata); end
    av_read = 0;
    tick();
    checks++; if (ram_wren !== 1'b1 || ram_addr !== 8'h02 || ram_wdata !== 32'h2222) begin errors++; $display("FAIL c2_jtag_next: got wren=%b addr=%h data=%h want 1 02 2222", ram_wren, ram_addr, ram_wdata); end
    tick();
  endtask

  task automatic test_overrun_reset();
    checks++; if (cmd_overrun !== 1'b0) begin errors++; $display("FAIL ovr_pre: got %b want 0", cmd_overrun); end
    av_read = 1;
    av_address = 8'h20;
    pulse_b(32'h3333);
    pulse_b(32'h4444);
    checks++; if (cmd_overrun !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b want 1", cmd_overrun); end
    repeat (6) tick();
    av_read = 0;
    tick();
    checks++; if (mem[8'h03] !== 32'h3333 || mem[8'h04] !== 32'h0) begin errors++; $display("FAIL ovr_ram: got %h %h want 3333 0", mem[8'h03], mem[8'h04]); end
    checks++; if (MonAReg !== 8'h04 || cmd_overrun !== 1'b1) begin errors++; $display("FAIL ovr_state: got addr=%h ovr=%b want 04 1", MonAReg, cmd_overrun); end
    pulse_a(8'h10, 1'b1);
    tick();
    reset_n = 0;
    #1;
    checks++; if (MonDReg !== 32'h0 || cmd_overrun !== 1'b0 || monitor_ready !== 1'b0) begin errors++; $display("FAIL rst_jrd: got data=%h ovr=%b ready=%b want 0 0 0", MonDReg, cmd_overrun, monitor_ready); end
    tick();
    reset_n = 1;
    repeat (3) tick();
    checks++; if (MonDReg !== 32'h0 || monitor_ready !== 1'b0 || MonAReg !== 8'h00 || ram_wren !== 1'b0) begin errors++; $display("FAIL rst_after: got data=%h ready=%b addr=%h wren=%b want 0 0 00 0", MonDReg, monitor_ready, MonAReg, ram_wren); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    test_reset();
    test_jtag_rw();
    test_wrap();
    test_cpu();
    test_contention();
    test_overrun_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
